// File: rtl/cla4_seq_arb_if.sv
// rtl/cla4_seq_arb_if.sv - request, adder-slice and result signals of cla4_seq_arb
// res_ovf exists only when CLA_SEQ_OVF_EN is defined.
interface cla4_seq_arb_if #(parameter int NDIG = 4);
    localparam int WIDTH = 4 * NDIG;

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic [3:0]       dp_a;
    logic [3:0]       dp_b;
    logic             dp_cin;
    logic [3:0]       dp_sum;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;
`ifdef CLA_SEQ_OVF_EN
    logic             res_ovf;
`endif

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        input  dp_sum, res_ready,
        output req0_ready, req1_ready, dp_a, dp_b, dp_cin,
        output res_valid, res_sum, res_cout, res_id
`ifdef CLA_SEQ_OVF_EN
        , output res_ovf
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        output dp_sum, res_ready,
        input  req0_ready, req1_ready, dp_a, dp_b, dp_cin,
        input  res_valid, res_sum, res_cout, res_id
`ifdef CLA_SEQ_OVF_EN
        , input res_ovf
`endif
    );
endinterface

// File: rtl/cla4_seq_arb.sv
// rtl/cla4_seq_arb.sv - round-robin digit-serial controller for a shared 4-bit CLA slice
// Optional signed-overflow output res_ovf under CLA_SEQ_OVF_EN.
module cla4_seq_arb #(
    parameter int NDIG = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    cla4_seq_arb_if.slave   bus
);
    localparam int WIDTH = 4 * NDIG;
    localparam int KW    = $clog2(NDIG);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic             ptr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             carry_q;
    logic [KW-1:0]    k;
    logic [KW+1:0]    base;
    logic             grant0;
    logic             grant1;
    logic             c;
    logic             last;

    // ptr names the last winner; on a tie the other port is granted
    assign grant0 = reset_n && (state == IDLE) && bus.req0_valid && (!bus.req1_valid || ptr);
    assign grant1 = reset_n && (state == IDLE) && bus.req1_valid && (!bus.req0_valid || !ptr);
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign base       = {k, 2'b00};
    assign last       = (k == KW'(NDIG - 1));
    assign bus.dp_a   = (state == RUN) ? a_q[base +: 4] : 4'd0;
    assign bus.dp_b   = (state == RUN) ? b_q[base +: 4] : 4'd0;
    assign bus.dp_cin = (state == RUN) ? ((k == '0) ? cin_q : carry_q) : 1'b0;

    // carry out of the digit recovered from the MSBs of operands and sum
    assign c = (bus.dp_a[3] & bus.dp_b[3]) | ((bus.dp_a[3] | bus.dp_b[3]) & ~bus.dp_sum[3]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= 1'b1;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            carry_q       <= 1'b0;
            k             <= '0;
            bus.res_valid <= 1'b0;
            bus.res_sum   <= '0;
            bus.res_cout  <= 1'b0;
            bus.res_id    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
            bus.res_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_q         <= grant1 ? bus.req1_a : bus.req0_a;
                        b_q         <= grant1 ? bus.req1_b : bus.req0_b;
                        cin_q       <= grant1 ? bus.req1_cin : bus.req0_cin;
                        bus.res_id  <= grant1;
                        ptr         <= grant1;
                        k           <= '0;
                        bus.res_sum <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    bus.res_sum[base +: 4] <= bus.dp_sum;
                    carry_q                <= c;
                    k                      <= k + 1'b1;
                    if (last) begin
                        bus.res_cout  <= c;
                        bus.res_valid <= 1'b1;
`ifdef CLA_SEQ_OVF_EN
                        bus.res_ovf   <= (bus.dp_a[3] == bus.dp_b[3]) && (bus.dp_sum[3] != bus.dp_a[3]);
`endif
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla4_seq_arb.sv
// tb/tb_cla4_seq_arb.sv - directed bench for cla4_seq_arb with a cycle-level reference model
module tb_cla4_seq_arb;
    localparam int NDIG = 4;

    logic clk;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    cla4_seq_arb_if #(.NDIG(NDIG)) bus ();
    cla4_seq_arb #(.NDIG(NDIG)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    assign bus.dp_sum = bus.dp_a + bus.dp_b + {3'b000, bus.dp_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: m_cnt = 0 idle, 1..NDIG digit k=m_cnt-1, NDIG+1 result held
    bit      started = 0;
    int      m_cnt = 0;
    bit      m_ptr = 1;
    longint  ma, mb;
    bit      mcin, mid;

    function automatic int winner();
        if (!reset_n || m_cnt != 0) return -1;
        if (bus.req0_valid && bus.req1_valid) return (m_ptr == 1'b1) ? 0 : 1;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner();
        cyc <= cyc + 1;
        if (!reset_n) begin
            started <= 1;
            m_cnt   <= 0;
            m_ptr   <= 1;
        end else if (m_cnt == 0) begin
            if (w >= 0) begin
                ma    <= (w == 1) ? longint'(bus.req1_a) : longint'(bus.req0_a);
                mb    <= (w == 1) ? longint'(bus.req1_b) : longint'(bus.req0_b);
                mcin  <= (w == 1) ? bus.req1_cin : bus.req0_cin;
                mid   <= (w == 1);
                m_ptr <= (w == 1);
                m_cnt <= 1;
            end
        end else if (m_cnt <= NDIG) begin
            m_cnt <= m_cnt + 1;
        end else if (bus.res_ready) begin
            m_cnt <= 0;
        end
    end

    int gid[$];
    int gcyc[$];

    always @(negedge clk) begin
        int w, k;
        longint mask, full, cin_k;
        if (started) begin
            w = winner();
            chk("req0_ready", bus.req0_ready, w == 0);
            chk("req1_ready", bus.req1_ready, w == 1);
            chk("res_valid", bus.res_valid, m_cnt == NDIG + 1);
            full = ma + mb + longint'(mcin);
            if (m_cnt >= 1 && m_cnt <= NDIG) begin
                k     = m_cnt - 1;
                mask  = (64'd1 << (4 * k)) - 1;
                cin_k = (((ma & mask) + (mb & mask) + longint'(mcin)) >> (4 * k)) & 1;
                chk("dp_a", bus.dp_a, 32'((ma >> (4 * k)) & 15));
                chk("dp_b", bus.dp_b, 32'((mb >> (4 * k)) & 15));
                chk("dp_cin", bus.dp_cin, 32'(cin_k));
            end else begin
                chk("dp_a_idle", bus.dp_a, 0);
                chk("dp_b_idle", bus.dp_b, 0);
                chk("dp_cin_idle", bus.dp_cin, 0);
            end
            if (m_cnt == NDIG + 1) begin
                chk("res_sum", bus.res_sum, 32'(full & 16'hFFFF));
                chk("res_cout", bus.res_cout, 32'((full >> 16) & 1));
                chk("res_id", bus.res_id, mid);
`ifdef CLA_SEQ_OVF_EN
                chk("res_ovf", bus.res_ovf,
                    32'(((ma >> 15) & 1) == ((mb >> 15) & 1) && ((full >> 15) & 1) != ((ma >> 15) & 1)));
`endif
            end
            if (bus.req0_valid && bus.req0_ready) begin gid.push_back(0); gcyc.push_back(cyc); end
            if (bus.req1_valid && bus.req1_ready) begin gid.push_back(1); gcyc.push_back(cyc); end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    bit dpc_log[4];
    bit last_ovf;

    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin,
                         output int gc);
        bit got = 0;
        if (id) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin; end
        else    begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin; end
        gc = cyc;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin got = 1; break; end
        end
        if (!got) chk("grant_timeout", 0, 1);
        gc = cyc;
        step();
        if (id) bus.req1_valid = 0; else bus.req0_valid = 0;
    endtask

    task automatic wait_res(input int gc, output logic [15:0] s, output bit co, output bit rid,
                            output int lat);
        bit got = 0;
        int j;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            j = cyc - gc;
            if (j >= 1 && j <= 4) dpc_log[j-1] = bus.dp_cin;
            if (bus.res_valid) begin got = 1; break; end
        end
        if (!got) chk("result_timeout", 0, 1);
        lat = cyc - gc;
        s   = bus.res_sum;
        co  = bus.res_cout;
        rid = bus.res_id;
`ifdef CLA_SEQ_OVF_EN
        last_ovf = bus.res_ovf;
`endif
        step();
    endtask

    initial begin
        int gc, lat;
        logic [15:0] s, s_hold;
        bit co, rid;

        reset_n = 0;
        bus.req0_valid = 0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 0;
        bus.req1_valid = 0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 0;
        bus.res_ready = 1;
        repeat (3) step();
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_sum", bus.res_sum, 0);
        reset_n = 1;
        step();

        // basic add from requester 0
        issue(0, 16'h1234, 16'h0FFF, 0, gc);
        wait_res(gc, s, co, rid, lat);
        chk("t1_sum", s, 16'h2233);
        chk("t1_cout", co, 0);
        chk("t1_id", rid, 0);
        chk("t1_latency", lat, 5);

        // full carry ripple through every digit, via requester 1
        issue(1, 16'hFFFF, 16'h0000, 1, gc);
        wait_res(gc, s, co, rid, lat);
        chk("t2_sum", s, 16'h0000);
        chk("t2_cout", co, 1);
        chk("t2_id", rid, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_dp_cin%0d", i), dpc_log[i], 1);

        // both requesters saturating: alternation and issue interval
        gid.delete(); gcyc.delete();
        bus.req0_valid = 1; bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_cin = 0;
        bus.req1_valid = 1; bus.req1_a = 16'h0F0F; bus.req1_b = 16'h00F1; bus.req1_cin = 1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (gid.size() >= 4) break;
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        wait_res(gcyc.size() > 0 ? gcyc[gcyc.size()-1] : cyc, s, co, rid, lat);
        chk("t3_ngrants", gid.size(), 4);
        if (gid.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("t3_gid%0d", i), gid[i], i % 2);
            for (int i = 0; i < 3; i++) chk($sformatf("t3_gap%0d", i), gcyc[i+1] - gcyc[i], 6);
        end

        // backpressure in DONE while requester 1 waits
        bus.res_ready = 0;
        issue(0, 16'hABCD, 16'h1234, 0, gc);
        wait_res(gc, s_hold, co, rid, lat);
        chk("t4_sum", s_hold, 16'hBE01);
        bus.req1_valid = 1; bus.req1_a = 16'h0001; bus.req1_b = 16'hFFFF; bus.req1_cin = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", bus.res_valid, 1);
            chk("t4_hold_sum", bus.res_sum, s_hold);
            chk("t4_req1_blocked", bus.req1_ready, 0);
            step();
        end
        bus.res_ready = 1;
        @(negedge clk);
        chk("t4_req1_blocked_last", bus.req1_ready, 0);
        step();
        @(negedge clk);
        chk("t4_req1_grant", bus.req1_ready, 1);
        gc = cyc;
        step();
        bus.req1_valid = 0;
        wait_res(gc, s, co, rid, lat);
        chk("t4b_sum", s, 16'h0000);
        chk("t4b_cout", co, 1);
        chk("t4b_id", rid, 1);

        // reset while digit 2 is on the slice
        issue(0, 16'h5555, 16'h3333, 0, gc);
        step();
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        @(negedge clk);
        chk("t5_res_valid", bus.res_valid, 0);
        chk("t5_res_sum", bus.res_sum, 0);
        chk("t5_res_cout", bus.res_cout, 0);
        chk("t5_res_id", bus.res_id, 0);
        chk("t5_dp_a", bus.dp_a, 0);
        chk("t5_dp_cin", bus.dp_cin, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t5_no_result", bus.res_valid, 0);
        end
        step();
        issue(0, 16'h0001, 16'h0001, 0, gc);
        wait_res(gc, s, co, rid, lat);
        chk("t5_sum", s, 16'h0002);

`ifdef CLA_SEQ_OVF_EN
        issue(0, 16'h7FFF, 16'h0001, 0, gc);
        wait_res(gc, s, co, rid, lat);
        chk("ovf1_sum", s, 16'h8000);
        chk("ovf1_flag", last_ovf, 1);
        issue(0, 16'h8000, 16'h7FFF, 0, gc);
        wait_res(gc, s, co, rid, lat);
        chk("ovf0_flag", last_ovf, 0);
`endif

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cla4_seq_arb.md
Name: cla4_seq_arb

Overview:
- Digit-serial controller that shares one external 4-bit carry-lookahead adder slice between two requesters.
- Accepts a WIDTH-bit add request, 4*NDIG bits wide, from either port under round-robin arbitration.
- Feeds the operands to the slice one 4-bit digit per cycle, LSB first, and registers a carry between digits.
- Returns the assembled sum, carry-out and requester ID over a valid/ready result port.

Parameters:
- NDIG, 4, number of 4-bit digits per operand; WIDTH = 4*NDIG; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset, sampled on clk
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a  input  WIDTH  operand A, requester 0
- req0_b  input  WIDTH  operand B, requester 0
- req0_cin  input  1  carry-in, requester 0
- req1_valid / req1_ready / req1_a / req1_b / req1_cin  same widths and meanings, requester 1
- dp_a  output  4  digit of A presented to slice
- dp_b  output  4  digit of B presented to slice
- dp_cin  output  1  carry into slice
- dp_sum  input  4  combinational sum returned by slice
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  assembled sum
- res_cout  output  1  carry out of MSB digit
- res_id  output  1  requester that issued the operation

Behaviour:
- Reset (reset_n=0 at clk edge):
  - State=IDLE.
  - req0_ready=req1_ready=0, res_valid=0, res_sum=0, res_cout=0, res_id=0.
  - dp_a=dp_b=0, dp_cin=0, digit counter=0.
  - Round-robin pointer=1, so requester 0 wins the first tie.
  - Reset mid-operation discards the operation; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - req*_ready are combinational grants, asserted only in IDLE.
  - Only one valid: that port is granted.
  - Both valid: grant the port that is not the pointer. The pointer then updates to the granted port.
  - On grant: latch A, B, cin and ID; clear counter and sum register; go to RUN.
  - Handshake completes on the same cycle as grant (valid&&ready).
- RUN (exactly NDIG cycles, counter k=0..NDIG-1):
  - dp_a=A[4k+3:4k], dp_b=B[4k+3:4k].
  - dp_cin = latched cin when k=0, otherwise the registered carry.
  - Each edge: store dp_sum into sum[4k+3:4k].
  - Digit carry c = (dp_a[3]&dp_b[3]) | ((dp_a[3]|dp_b[3]) & ~dp_sum[3]); register c as the next carry.
  - At k=NDIG-1: res_cout<=c, go to DONE.
- dp_* outputs are don't-care outside RUN but are held at 0.
- DONE:
  - res_valid=1; res_sum, res_cout and res_id are stable.
  - res_valid&&res_ready: go to IDLE, res_valid<=0.
  - No new grant in the same cycle, so there is one bubble cycle.
- Latency and throughput:
  - Grant edge to res_valid is NDIG+1 cycles.
  - Minimum issue interval is NDIG+2 cycles with res_ready held high.
- Requester behaviour:
  - Requesters hold valid and operands until ready.
  - Operands are sampled only at grant, so later changes are ignored.
- Backpressure: res_ready low holds DONE indefinitely; both req*_ready stay 0 meanwhile.
- Arithmetic: unsigned modulo 2^WIDTH; res_cout is bit WIDTH of A+B+cin.

Optional Feature:
- Macro CLA_SEQ_OVF_EN.
- Defined: adds output res_ovf (1 bit), reset 0.
  - Computed at the final digit as (dp_a[3]==dp_b[3]) && (dp_sum[3]!=dp_a[3]).
  - This is two's-complement signed overflow of A+B+cin.
  - Valid with res_valid.
- Undefined: port res_ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req0: A=0x1234, B=0x0FFF, cin=0, NDIG=4 -> req0_ready 1 cycle. Then res_valid 5 cycles after grant with res_sum=0x2233, res_cout=0, res_id=0.
- Full-width carry chain: A=0xFFFF, B=0x0000, cin=1 -> res_sum=0x0000, res_cout=1. Also check dp_cin per digit is 1,1,1,1.
- Both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1. Each result's res_id matches its grant, and the issue interval is 6 cycles.
- res_ready=0 for 10 cycles in DONE, with req1 valid -> res_* stable, req1_ready=0 throughout. req1 is granted the cycle after DONE exits.
- reset_n=0 during RUN digit 2 -> next cycle all outputs are at reset values and no res_valid appears. A new req0 A=0x0001, B=0x0001 gives res_sum=0x0002.
- With CLA_SEQ_OVF_EN: A=0x7FFF, B=0x0001 -> res_ovf=1, res_sum=0x8000. A=0x8000, B=0x7FFF -> res_ovf=0.
